// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: next-PC select encodings and fetch FSM state codes,
// common to the fetch unit and the control unit.
package fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RETURN = 2'b11;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_DONE = 2'd3
  } fetch_state_e;

  // Legacy-compatible constant form of the same state codes.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic pc_src_pops(input logic [1:0] src);
    return src == PC_RETURN;
  endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Hardware return-address stack: push, pop, or replace-top when both are
// requested in the same cycle. Illegal pushes (full) and pops (empty) are ignored.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] IDX_ONE  = PW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW:0]   r_count;
  logic [PW-1:0] w_top_idx;
  logic [PW-1:0] w_wr_idx;
  logic          w_do_pop;
  logic          w_do_push;

  // The count doubles as the write pointer; when full its low bits wrap to 0,
  // so top index = low bits - 1 still lands on the last entry.
  assign w_wr_idx  = r_count[PW-1:0];
  assign w_top_idx = r_count[PW-1:0] - IDX_ONE;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign top   = r_mem[w_top_idx];

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (w_do_pop | ~full);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_count <= r_count + 1'b1;
    end else if (w_do_pop && !w_do_push) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      if (w_do_pop) begin
        r_mem[w_top_idx] <= push_data;
      end else begin
        r_mem[w_wr_idx] <= push_data;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder: fetch_en/fetch_done handshake with the control
// unit, next-PC selection, single-word imem read and the return-address stack.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic               fetch_done,
  input  logic [1:0]         pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               stack_push,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               stack_overflow,
  output logic               stack_underflow,
  output logic [1:0]         dbg_state
);

  // Handshake: fetch_en is a level request sampled in IDLE; fetch_done stays
  // high (with instr/pc stable) until fetch_en drops, then the FSM returns to IDLE.

  logic [1:0]         r_state;
  logic               r_first;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_fetch_done;
  logic               r_imem_req;
  logic               r_ovf;
  logic               r_unf;

  logic               w_start;
  logic               w_op;
  logic               w_ret;
  logic               w_pop;
  logic               w_push;
  logic               w_ras_full;
  logic               w_ras_empty;
  logic [ADDR_W-1:0]  w_ras_top;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_next_pc;

  assign w_start  = (r_state == ST_IDLE) && fetch_en;
  assign w_op     = w_start && !r_first;
  assign w_ret    = w_op && pc_src_pops(pc_src);
  assign w_pop    = w_ret && !w_ras_empty;
  assign w_push   = w_op && stack_push && (w_pop || !w_ras_full);
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_next_pc = w_pc_inc;
    case (pc_src)
      PC_BRANCH: w_next_pc = branch_target;
      PC_JUMP:   w_next_pc = jump_target;
      PC_RETURN: w_next_pc = w_ras_empty ? w_pc_inc : w_ras_top;
      default:   w_next_pc = w_pc_inc;
    endcase
  end

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b1;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_fetch_done <= 1'b0;
      r_imem_req   <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fetch_en) begin
            r_pc       <= r_first ? RESET_PC : w_next_pc;
            r_first    <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= ST_REQ;
            if (w_ret && w_ras_empty) begin
              r_unf <= 1'b1;
            end
            if (w_op && stack_push && !w_pop && w_ras_full) begin
              r_ovf <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          r_imem_req <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_instr      <= imem_rdata;
            r_fetch_done <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!fetch_en) begin
            r_fetch_done <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fetch_done      = r_fetch_done;
  assign imem_req        = r_imem_req;
  assign imem_addr       = r_imem_req ? r_pc : '0;
  assign instr           = r_instr;
  assign pc              = r_pc;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small memory responder drives imem, and each
// scenario task compares addresses, latencies and flags with hand-derived values.
module tb_fetch_unit;

  localparam logic [1:0] SEQ = 2'b00;
  localparam logic [1:0] BRA = 2'b01;
  localparam logic [1:0] JMP = 2'b10;
  localparam logic [1:0] RET = 2'b11;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        fetch_done;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        stack_push;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        stack_overflow;
  logic        stack_underflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .ADDR_W    (32),
    .INSTR_W   (32),
    .RAS_DEPTH (8),
    .RESET_PC  (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .fetch_done      (fetch_done),
    .pc_src          (pc_src),
    .branch_target   (branch_target),
    .jump_target     (jump_target),
    .stack_push      (stack_push),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .pc              (pc),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fetch_en = 1'b0; imem_rvalid = 1'b0; stack_push = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Cycle 0 is the cycle in which fetch_en is first presented in IDLE.
  task automatic fetch_one(input logic [1:0] src, input logic [31:0] bt,
                           input logic [31:0] jt, input logic push, input int lat,
                           input logic [31:0] data, output logic [31:0] addr,
                           output int req_cyc, output logic req_after,
                           output int done_cyc);
    int n;
    @(negedge clk);
    pc_src = src; branch_target = bt; jump_target = jt; stack_push = push;
    fetch_en = 1'b1;
    n = 0; addr = 32'hxxxx_xxxx; req_cyc = -1; req_after = 1'bx; done_cyc = -1;
    while (n < 8) begin
      @(negedge clk); n++;
      if (imem_req) begin
        req_cyc = n; addr = imem_addr;
        break;
      end
    end
    if (req_cyc < 0) begin
      n_checks++; n_errors++;
      $display("FAIL req_timeout: imem_req got 0 for 8 cycles, expected 1");
      return;
    end
    // Inputs other than fetch_en must be ignored outside the IDLE exit cycle.
    pc_src = 2'($urandom_range(3)); branch_target = $urandom; jump_target = $urandom;
    stack_push = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); n++;
      if (i == 0) req_after = imem_req;
    end
    imem_rvalid = 1'b1; imem_rdata = data;
    @(negedge clk); n++;
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    while (!fetch_done && n < 60) begin
      @(negedge clk); n++;
    end
    if (fetch_done) done_cyc = n;
    else begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: fetch_done got 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic release_fetch();
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({fetch_done, imem_req, stack_overflow, stack_underflow} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, expected 0000",
               {fetch_done, imem_req, stack_overflow, stack_underflow});
    end
    n_checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_regs: pc=%h instr=%h addr=%h, expected all 0", pc, instr, imem_addr);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL reset_state: got %0d, expected 0", dbg_state);
    end
  endtask

  task automatic test_first_fetch();
    logic [31:0] a; int rc; logic ra; int dc;
    do_reset();
    // First fetch ignores pc_src and stack_push entirely.
    fetch_one(JMP, 32'h0, 32'h77, 1'b1, 1, 32'hA5A5_0001, a, rc, ra, dc);
    n_checks++;
    if (a !== 32'h0 || rc != 1) begin
      n_errors++; $display("FAIL first_addr: addr=%h at cycle %0d, expected 0 at cycle 1", a, rc);
    end
    n_checks++;
    if (dc != 3) begin
      n_errors++; $display("FAIL first_latency: fetch_done at cycle %0d, expected 3", dc);
    end
    n_checks++;
    if (instr !== 32'hA5A5_0001 || pc !== 32'h0) begin
      n_errors++; $display("FAIL first_data: instr=%h pc=%h, expected a5a50001 / 0", instr, pc);
    end
    release_fetch();
    n_checks++;
    if (fetch_done !== 1'b0 || dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL first_release: done=%b state=%0d, expected 0/0", fetch_done, dbg_state);
    end
    // The ignored push must not have landed: a return now underflows to pc+1.
    fetch_one(RET, 32'h0, 32'h0, 1'b0, 1, 32'h1, a, rc, ra, dc);
    n_checks++;
    if (a !== 32'h1 || stack_underflow !== 1'b1) begin
      n_errors++; $display("FAIL first_no_push: addr=%h unf=%b, expected 1 / 1", a, stack_underflow);
    end
    release_fetch();
  endtask

  task automatic test_sequential();
    logic [31:0] a; int rc; logic ra; int dc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 4, 32'h1000 + k, a, rc, ra, dc);
      n_checks++;
      if (a !== k) begin
        n_errors++; $display("FAIL seq_addr[%0d]: got %h, expected %h", k, a, k);
      end
      n_checks++;
      if (ra !== 1'b0 || dc != 6) begin
        n_errors++; $display("FAIL seq_timing[%0d]: req_after=%b done_cyc=%0d, expected 0 / 6", k, ra, dc);
      end
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        n_checks++;
        if (fetch_done !== 1'b1 || instr !== 32'h1000 + k || pc !== k) begin
          n_errors++;
          $display("FAIL seq_hold[%0d]: done=%b instr=%h pc=%h, expected 1 / %h / %h",
                   k, fetch_done, instr, pc, 32'h1000 + k, k);
        end
      end
      release_fetch();
      n_checks++;
      if (fetch_done !== 1'b0) begin
        n_errors++; $display("FAIL seq_drop[%0d]: fetch_done=%b, expected 0", k, fetch_done);
      end
    end
  endtask

  task automatic test_jal_return();
    logic [31:0] a; int rc; logic ra; int dc;
    do_reset();
    fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    fetch_one(BRA, 32'h5, 32'h0, 1'b0, 2, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h5) begin n_errors++; $display("FAIL jal_branch: got %h, expected 5", a); end
    fetch_one(JMP, 32'h0, 32'h40, 1'b1, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h40) begin n_errors++; $display("FAIL jal_jump: got %h, expected 40", a); end
    fetch_one(RET, 32'h0, 32'h0, 1'b0, 3, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h6 || stack_underflow !== 1'b0) begin
      n_errors++; $display("FAIL jal_return: addr=%h unf=%b, expected 6 / 0", a, stack_underflow);
    end
    // Stack is now empty: one more return falls through to pc+1 and flags underflow.
    fetch_one(RET, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h7 || stack_underflow !== 1'b1) begin
      n_errors++; $display("FAIL jal_empty: addr=%h unf=%b, expected 7 / 1", a, stack_underflow);
    end
  endtask

  task automatic test_replace();
    logic [31:0] a; int rc; logic ra; int dc;
    do_reset();
    fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    fetch_one(JMP, 32'h0, 32'h20, 1'b1, 1, 32'h0, a, rc, ra, dc); release_fetch(); // push 1
    // Return plus push: go to old top (1), top becomes 0x21.
    fetch_one(RET, 32'h0, 32'h0, 1'b1, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h1) begin n_errors++; $display("FAIL replace_addr: got %h, expected 1", a); end
    fetch_one(RET, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h21 || stack_underflow !== 1'b0) begin
      n_errors++; $display("FAIL replace_top: addr=%h unf=%b, expected 21 / 0", a, stack_underflow);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] a; int rc; logic ra; int dc;
    logic [31:0] exp_a;
    do_reset();
    fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    // Pushes 1, 0x101..0x107 fill the stack; the ninth (0x108) is dropped.
    for (int k = 0; k < 9; k++) begin
      fetch_one(JMP, 32'h0, 32'h100 + k, 1'b1, $urandom_range(1, 3), 32'h0, a, rc, ra, dc);
      release_fetch();
      if (k == 7) begin
        n_checks++;
        if (stack_overflow !== 1'b0) begin
          n_errors++; $display("FAIL ovf_early: got %b after 8 pushes, expected 0", stack_overflow);
        end
      end
    end
    n_checks++;
    if (stack_overflow !== 1'b1 || a !== 32'h108) begin
      n_errors++; $display("FAIL ovf_set: ovf=%b addr=%h, expected 1 / 108", stack_overflow, a);
    end
    for (int r = 0; r < 8; r++) begin
      exp_a = (r < 7) ? 32'h107 - r : 32'h1;
      fetch_one(RET, 32'h0, 32'h0, 1'b0, $urandom_range(1, 3), 32'h0, a, rc, ra, dc);
      release_fetch();
      n_checks++;
      if (a !== exp_a) begin
        n_errors++; $display("FAIL ovf_pop[%0d]: got %h, expected %h", r, a, exp_a);
      end
    end
    n_checks++;
    if (stack_underflow !== 1'b0) begin
      n_errors++; $display("FAIL unf_early: got %b, expected 0", stack_underflow);
    end
    fetch_one(RET, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h2 || stack_underflow !== 1'b1 || stack_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL unf_set: addr=%h unf=%b ovf=%b, expected 2 / 1 / 1", a, stack_underflow, stack_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a; int rc; logic ra; int dc;
    do_reset();
    fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    fetch_one(BRA, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h0) begin n_errors++; $display("FAIL wrap_seq: got %h, expected 0", a); end
    fetch_one(BRA, 32'h10, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h10) begin n_errors++; $display("FAIL wrap_branch: got %h, expected 10", a); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; int rc; logic ra; int dc;
    do_reset();
    fetch_one(SEQ, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    fetch_one(JMP, 32'h0, 32'h33, 1'b1, 1, 32'h0, a, rc, ra, dc); release_fetch();
    @(negedge clk);
    pc_src = SEQ; stack_push = 1'b0; fetch_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h34) begin
      n_errors++; $display("FAIL mid_req: req=%b addr=%h, expected 1 / 34", imem_req, imem_addr);
    end
    @(negedge clk);
    reset = 1'b1; fetch_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if (fetch_done !== 1'b0 || dbg_state !== 2'd0 || pc !== 32'h0) begin
      n_errors++; $display("FAIL mid_reset: done=%b state=%0d pc=%h, expected 0 / 0 / 0", fetch_done, dbg_state, pc);
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    n_checks++;
    if (fetch_done !== 1'b0 || dbg_state !== 2'd0 || instr !== 32'h0) begin
      n_errors++; $display("FAIL mid_stale: done=%b state=%0d instr=%h, expected 0 / 0 / 0", fetch_done, dbg_state, instr);
    end
    fetch_one(JMP, 32'h0, 32'h99, 1'b1, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h0) begin n_errors++; $display("FAIL mid_refetch: got %h, expected 0", a); end
    // Stack was cleared by the reset: the earlier push of 0x1 is gone.
    fetch_one(RET, 32'h0, 32'h0, 1'b0, 1, 32'h0, a, rc, ra, dc); release_fetch();
    n_checks++;
    if (a !== 32'h1 || stack_underflow !== 1'b1) begin
      n_errors++; $display("FAIL mid_stack_clear: addr=%h unf=%b, expected 1 / 1", a, stack_underflow);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; fetch_en = 1'b0; pc_src = SEQ; branch_target = '0; jump_target = '0;
    stack_push = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_first_fetch();
    test_sequential();
    test_jal_return();
    test_replace();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch responder for the multi-cycle RISC core: answers the control unit's fetch-enable / fetch-done handshake, selects the next PC from the registered PC-source code, reads one instruction word from instruction memory, and maintains the hardware return-address stack used by JAL (push) and stop-bit return (pop). Sits between the control unit, the decode stage and the instruction memory port.

## Interface
- ADDR_W, 32: PC and instruction-memory address width (word addressed).
- INSTR_W, 32: instruction word width.
- RAS_DEPTH, 8: return-address stack entries (power of two, ≥2).
- RESET_PC, 0: PC of the first fetch after reset.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_en  in  1  fetch request from control unit (level).
- fetch_done  out  1  fetched instruction valid, handshake acknowledge.
- pc_src  in  2  next-PC select of the previously fetched instruction: 00 seq, 01 branch, 10 jump, 11 return.
- branch_target  in  ADDR_W  taken-branch target.
- jump_target  in  ADDR_W  J/JAL target.
- stack_push  in  1  push return address (JAL).
- imem_req  out  1  one-cycle read strobe.
- imem_addr  out  ADDR_W  read address, valid while imem_req.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  INSTR_W  read data.
- instr  out  INSTR_W  last fetched instruction (held).
- pc  out  ADDR_W  address of instr.
- stack_overflow  out  1  sticky, push while full.
- stack_underflow  out  1  sticky, pop while empty.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE; first_fetch=1, pc=RESET_PC, instr=0, stack empty, all outputs 0 except pc.
- IDLE & fetch_en: compute next pc, apply stack op, go REQ. first_fetch: next pc=RESET_PC, no stack op, pc_src/stack_push ignored, clear first_fetch.
- Next pc (not first): 00 → pc+1; 01 → branch_target; 10 → jump_target; 11 → stack top, pop. Arithmetic modulo 2^ADDR_W (pc+1 wraps to 0).
- stack_push: pushes pc+1 of the current (pre-update) pc.
- pc_src=11 with stack_push: next pc=old top; top replaced by pc+1; count unchanged.
- Pop on empty: next pc=pc+1, stack_underflow set, count stays 0.
- Push on full (without pop): push dropped, stack_overflow set, contents unchanged.
- REQ: imem_req=1, imem_addr=pc, exactly one cycle → WAIT.
- WAIT: on imem_rvalid latch instr=imem_rdata → DONE; otherwise stay (no timeout).
- DONE: fetch_done=1; stay while fetch_en=1; fetch_en=0 → IDLE.
- imem_rvalid outside WAIT ignored.
- Sticky flags clear only on reset.

## Timing
- Cycle 0: fetch_en sampled high in IDLE; pc updates at end of cycle.
- Cycle 1: imem_req=1, imem_addr=new pc.
- Cycle ≥2: imem_rvalid sampled; memory latency ≥1 cycle.
- fetch_done rises the cycle after rvalid; min fetch latency 3 cycles from fetch_en to fetch_done.
- fetch_done, instr, pc registered; pc stable from cycle 1 until next IDLE exit.
- pc_src, targets, stack_push sampled only in the IDLE→REQ cycle.
- Reset mid-fetch (REQ/WAIT/DONE): IDLE next cycle, fetch_done=0, outstanding rvalid discarded, stack cleared.

## Structure
- Shared package: pc_src encodings (PC_SEQ, PC_BRANCH, PC_JUMP, PC_RETURN), fetch state enum, shared with control unit.
- Sub-module return_stack: RAS_DEPTH×ADDR_W array, pointer/count, push/pop/replace, full/empty outputs.

## Test plan
- Reset, fetch_en=1, memory returns 0xA5A5_0001 after 1 cycle -> imem_addr=0, fetch_done on cycle 3, instr=0xA5A5_0001, pc=0.
- Sequential run of 3 fetches, pc_src=00, rvalid delayed 4 cycles -> addresses 0,1,2; fetch_done held until fetch_en drops.
- pc=5, pc_src=10, jump_target=0x40, stack_push=1; next fetch pc_src=11 -> fetches at 0x40 then 6; stack empty after.
- Push 9 times with RAS_DEPTH=8 -> stack_overflow=1, 8 returns yield newest-first addresses, 9th pop sets stack_underflow, pc=pc+1.
- pc=0xFFFF_FFFF, pc_src=00 -> next imem_addr=0; pc_src=01, branch_target=0x10 -> 0x10.
- Reset asserted in WAIT, stale rvalid arrives next cycle -> fetch_done stays 0, next fetch at RESET_PC.
